// File: rtl/md_issue_ctrl_pkg.sv
// Shared encodings and constants for the mult/div issue controller.
package md_issue_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    WB_PEND = 2'd2
  } md_state_e;

  localparam logic [4:0]  RSTATUS_REG   = 5'd30;
  localparam logic [31:0] MULT_EXC_CODE = 32'd4;
  localparam logic [31:0] DIV_EXC_CODE  = 32'd5;

  function automatic logic [31:0] exc_code(input logic is_div);
    return is_div ? DIV_EXC_CODE : MULT_EXC_CODE;
  endfunction

endpackage

// File: rtl/md_issue_ctrl_if.sv
// Pipeline-facing bundle of the mult/div issue controller.
interface md_issue_ctrl_if;
  logic [4:0]  fd_readRegA;
  logic [4:0]  fd_readRegB;
  logic        fd_usesB;
  logic        fd_writes_rd;
  logic [4:0]  fd_rd;
  logic        dx_is_mult;
  logic        dx_is_div;
  logic [4:0]  dx_rd;
  logic [31:0] md_result;
  logic        md_ready;
  logic        md_exception;
  logic        mw_writes;
  logic        md_ctrl_mult;
  logic        md_ctrl_div;
  logic        stall_fd;
  logic        hold_mw;
  logic        md_wb_en;
  logic [4:0]  md_wb_rd;
  logic [31:0] md_wb_data;
  logic        md_busy;
  logic        md_timeout;

  modport master (
    output fd_readRegA, fd_readRegB, fd_usesB, fd_writes_rd, fd_rd,
           dx_is_mult, dx_is_div, dx_rd, md_result, md_ready, md_exception, mw_writes,
    input  md_ctrl_mult, md_ctrl_div, stall_fd, hold_mw, md_wb_en, md_wb_rd,
           md_wb_data, md_busy, md_timeout
  );

  modport slave (
    input  fd_readRegA, fd_readRegB, fd_usesB, fd_writes_rd, fd_rd,
           dx_is_mult, dx_is_div, dx_rd, md_result, md_ready, md_exception, mw_writes,
    output md_ctrl_mult, md_ctrl_div, stall_fd, hold_mw, md_wb_en, md_wb_rd,
           md_wb_data, md_busy, md_timeout
  );
endinterface

// File: rtl/md_hazard_cmp.sv
// Combinational RAW/WAW compare of the F/D instruction against the pending mult/div destination.
module md_hazard_cmp
  import md_issue_ctrl_pkg::*;
(
  input  logic       i_busy,
  input  logic       i_exc_chk,
  input  logic [4:0] i_pend_rd,
  input  logic [4:0] i_rs_a,
  input  logic [4:0] i_rs_b,
  input  logic       i_uses_b,
  input  logic       i_writes_rd,
  input  logic [4:0] i_rd,
  output logic       o_stall
);

  // r0 is never a real dependency, so a zero target never matches.
  function automatic logic reg_hit(input logic [4:0] r, input logic [4:0] a,
                                   input logic [4:0] b, input logic ub,
                                   input logic wr, input logic [4:0] d);
    return (r != 5'd0) && ((a == r) || (ub && (b == r)) || (wr && (d == r)));
  endfunction

  logic w_hit_pend;
  logic w_hit_rstat;

  assign w_hit_pend  = reg_hit(i_pend_rd, i_rs_a, i_rs_b, i_uses_b, i_writes_rd, i_rd);
  assign w_hit_rstat = i_exc_chk & reg_hit(RSTATUS_REG, i_rs_a, i_rs_b, i_uses_b, i_writes_rd, i_rd);
  assign o_stall     = i_busy & (w_hit_pend | w_hit_rstat);

endmodule

// File: rtl/md_issue_ctrl.sv
// Mult/div issue scheduler: one-entry scoreboard, F/D stall and write-port arbitration.
// Optional MD_EXCEPTION_EN: exceptions redirect the writeback to r30 with a cause code.
module md_issue_ctrl
  import md_issue_ctrl_pkg::*;
#(
  parameter int MD_TIMEOUT = 40,
  parameter int CNT_W      = 6
) (
  input  logic         clock,
  input  logic         reset,
  md_issue_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_TIMEOUT - 1);

  md_state_e         r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [4:0]        r_pend_rd, r_wb_rd;
  logic [31:0]       r_wb_data;
  logic              r_wb_en, r_is_div, r_timeout;
  logic              w_issue, w_busy, w_hz_stall, w_exc_chk;
  logic              w_ctrl_mult, w_ctrl_div, w_hold;
  logic              w_wb_en, w_res_en;
  logic [4:0]        w_wb_rd, w_res_rd;
  logic [31:0]       w_wb_data, w_res_data;

  assign w_issue = bus.dx_is_mult | bus.dx_is_div;
  assign w_busy  = (r_state != IDLE);

  // Destination and data the unit's result would be written with this cycle.
  always_comb begin
    w_res_rd   = r_pend_rd;
    w_res_data = bus.md_result;
    w_res_en   = (r_pend_rd != 5'd0);
`ifdef MD_EXCEPTION_EN
    if (bus.md_exception) begin
      w_res_rd   = RSTATUS_REG;
      w_res_data = exc_code(r_is_div);
      w_res_en   = 1'b1;
    end
`endif
  end

`ifdef MD_EXCEPTION_EN
  assign w_exc_chk = 1'b1;
`else
  logic w_unused_exc;
  assign w_unused_exc = bus.md_exception;
  assign w_exc_chk    = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_ctrl_mult = 1'b0;
    w_ctrl_div  = 1'b0;
    w_hold      = 1'b0;
    w_wb_en     = 1'b0;
    w_wb_rd     = 5'd0;
    w_wb_data   = 32'd0;
    unique case (r_state)
      IDLE: begin
        if (w_issue) begin
          w_ctrl_mult = bus.dx_is_mult;
          w_ctrl_div  = bus.dx_is_div & ~bus.dx_is_mult;
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (bus.md_ready) begin
          if (!bus.mw_writes) begin
            w_wb_en     = w_res_en;
            w_wb_rd     = w_res_rd;
            w_wb_data   = w_res_data;
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt = WB_PEND;
          end
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = IDLE;
        end
      end
      WB_PEND: begin
        w_hold      = 1'b1;
        w_wb_en     = r_wb_en;
        w_wb_rd     = r_wb_rd;
        w_wb_data   = r_wb_data;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_pend_rd <= 5'd0;
      r_is_div  <= 1'b0;
      r_wb_en   <= 1'b0;
      r_wb_rd   <= 5'd0;
      r_wb_data <= 32'd0;
      r_timeout <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE && w_issue) begin
        r_cnt     <= '0;
        r_pend_rd <= bus.dx_rd;
        r_is_div  <= bus.dx_is_div & ~bus.dx_is_mult;
        r_wb_en   <= 1'b0;
        r_wb_rd   <= 5'd0;
        r_wb_data <= 32'd0;
        r_timeout <= 1'b0;
      end else if (r_state == BUSY) begin
        r_cnt <= r_cnt + CNT_W'(1);
        if (bus.md_ready && bus.mw_writes) begin
          r_wb_en   <= w_res_en;
          r_wb_rd   <= w_res_rd;
          r_wb_data <= w_res_data;
        end else if (!bus.md_ready && r_cnt == CNT_LAST) begin
          r_timeout <= 1'b1;
        end
      end
    end
  end

  md_hazard_cmp u_hazard (
    .i_busy      (w_busy),
    .i_exc_chk   (w_exc_chk),
    .i_pend_rd   (r_pend_rd),
    .i_rs_a      (bus.fd_readRegA),
    .i_rs_b      (bus.fd_readRegB),
    .i_uses_b    (bus.fd_usesB),
    .i_writes_rd (bus.fd_writes_rd),
    .i_rd        (bus.fd_rd),
    .o_stall     (w_hz_stall)
  );

  // Start pulses are combinational from D/X, so gate them while reset is held.
  assign bus.md_ctrl_mult = w_ctrl_mult & reset;
  assign bus.md_ctrl_div  = w_ctrl_div & reset;
  assign bus.stall_fd     = w_hz_stall | w_hold;
  assign bus.hold_mw      = w_hold;
  assign bus.md_wb_en     = w_wb_en;
  assign bus.md_wb_rd     = w_wb_rd;
  assign bus.md_wb_data   = w_wb_data;
  assign bus.md_busy      = w_busy;
  assign bus.md_timeout   = r_timeout;

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Scoreboard bench for md_issue_ctrl: issue, stall, port stealing, timeout and reset.
module tb_md_issue_ctrl;

  localparam int TO = 40;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  wb_t  sb_q[$];

  md_issue_ctrl_if bus ();

  md_issue_ctrl #(.MD_TIMEOUT(TO), .CNT_W(6)) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Every write the DUT performs must match the oldest expected write.
  always @(negedge clk) begin
    #2;
    if (bus.md_wb_en === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("wb_unexpected", 32'd1, 32'd0);
      end else begin
        wb_t e;
        e = sb_q.pop_front();
        chk("wb_rd", {27'd0, bus.md_wb_rd}, {27'd0, e.rd});
        chk("wb_data", bus.md_wb_data, e.data);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    bus.fd_readRegA = 5'd0; bus.fd_readRegB = 5'd0; bus.fd_usesB = 1'b0;
    bus.fd_writes_rd = 1'b0; bus.fd_rd = 5'd0;
    bus.dx_is_mult = 1'b0; bus.dx_is_div = 1'b0; bus.dx_rd = 5'd0;
    bus.md_result = 32'd0; bus.md_ready = 1'b0; bus.md_exception = 1'b0;
    bus.mw_writes = 1'b0;
  endtask

  task automatic set_fd(input logic [4:0] a, input logic [4:0] b, input logic ub,
                        input logic wr, input logic [4:0] d);
    bus.fd_readRegA = a; bus.fd_readRegB = b; bus.fd_usesB = ub;
    bus.fd_writes_rd = wr; bus.fd_rd = d;
  endtask

  // Present an op in D/X for one cycle; leaves the DUT in its first BUSY cycle.
  task automatic issue(input logic m, input logic d, input logic [4:0] rd, input string tag);
    bus.dx_is_mult = m; bus.dx_is_div = d; bus.dx_rd = rd;
    settle();
    chk({tag, "_ctrl_mult"}, {31'd0, bus.md_ctrl_mult}, {31'd0, m});
    chk({tag, "_ctrl_div"}, {31'd0, bus.md_ctrl_div}, {31'd0, d & ~m});
    chk({tag, "_stall_issue"}, {31'd0, bus.stall_fd}, 32'd0);
    tick();
    bus.dx_is_mult = 1'b0; bus.dx_is_div = 1'b0; bus.dx_rd = 5'd0;
    settle();
    chk({tag, "_busy"}, {31'd0, bus.md_busy}, 32'd1);
    chk({tag, "_ctrl_off"}, {30'd0, bus.md_ctrl_mult, bus.md_ctrl_div}, 32'd0);
  endtask

  task automatic run_busy(input int n, input logic exp_stall, input string tag);
    for (int i = 0; i < n; i++) begin
      settle();
      if (bus.md_busy !== 1'b1 || bus.md_wb_en !== 1'b0 || bus.stall_fd !== exp_stall
          || bus.md_timeout !== 1'b0)
        chk({tag, "_busy_run"}, {28'd0, bus.md_busy, bus.md_wb_en, bus.stall_fd, bus.md_timeout},
            {28'd0, 1'b1, 1'b0, exp_stall, 1'b0});
      tick();
    end
  endtask

  // Result arrives with the write port free; optionally expect a write.
  task automatic ready_free(input logic [31:0] data, input logic [4:0] wrd,
                            input logic [31:0] wdata, input logic exp_en, input string tag);
    bus.md_ready = 1'b1; bus.md_result = data; bus.mw_writes = 1'b0;
    if (exp_en) sb_q.push_back('{rd: wrd, data: wdata});
    settle();
    chk({tag, "_wb_en"}, {31'd0, bus.md_wb_en}, {31'd0, exp_en});
    chk({tag, "_hold"}, {31'd0, bus.hold_mw}, 32'd0);
    tick();
    bus.md_ready = 1'b0; bus.md_result = 32'd0; bus.md_exception = 1'b0;
    settle();
    chk({tag, "_idle_busy"}, {31'd0, bus.md_busy}, 32'd0);
    chk({tag, "_wb_off"}, {31'd0, bus.md_wb_en}, 32'd0);
  endtask

  initial begin
    clear_inputs();
    bus.dx_is_mult = 1'b1; bus.dx_rd = 5'd5;
    tick(); tick();
    settle();
    chk("rst_outputs", {23'd0, bus.md_ctrl_mult, bus.md_ctrl_div, bus.stall_fd, bus.hold_mw,
        bus.md_wb_en, bus.md_busy, bus.md_timeout, 2'd0}, 32'd0);
    chk("rst_wb_rd_data", {bus.md_wb_data[26:0], bus.md_wb_rd}, 32'd0);
    clear_inputs();
    rst_n = 1'b1;
    tick();

    // mul r5, result on the 32nd BUSY cycle, port free
    issue(1'b1, 1'b0, 5'd5, "mul5");
    run_busy(31, 1'b0, "mul5");
    ready_free(32'hDEAD_BEEF, 5'd5, 32'hDEAD_BEEF, 1'b1, "mul5");

    // RAW on r5 via rs_a; no stall in the issue cycle itself
    set_fd(5'd5, 5'd1, 1'b1, 1'b1, 5'd6);
    issue(1'b1, 1'b0, 5'd5, "raw");
    run_busy(3, 1'b1, "raw");
    set_fd(5'd1, 5'd5, 1'b0, 1'b1, 5'd6);
    settle();
    chk("rs_b_unused", {31'd0, bus.stall_fd}, 32'd0);
    set_fd(5'd1, 5'd5, 1'b1, 1'b1, 5'd6);
    settle();
    chk("rs_b_raw", {31'd0, bus.stall_fd}, 32'd1);
    set_fd(5'd1, 5'd2, 1'b1, 1'b1, 5'd5);
    settle();
    chk("waw", {31'd0, bus.stall_fd}, 32'd1);
    set_fd(5'd1, 5'd2, 1'b1, 1'b0, 5'd5);
    settle();
    chk("no_write_no_waw", {31'd0, bus.stall_fd}, 32'd0);
    set_fd(5'd5, 5'd1, 1'b1, 1'b1, 5'd6);
    tick();
    bus.md_ready = 1'b1; bus.md_result = 32'h0000_1234;
    sb_q.push_back('{rd: 5'd5, data: 32'h0000_1234});
    settle();
    chk("raw_wb_cycle_stall", {31'd0, bus.stall_fd}, 32'd1);
    tick();
    bus.md_ready = 1'b0;
    settle();
    chk("raw_after_wb_stall", {31'd0, bus.stall_fd}, 32'd0);
    clear_inputs();

    // div r7 with the write port taken by M/W
    issue(1'b0, 1'b1, 5'd7, "div7");
    run_busy(5, 1'b0, "div7");
    bus.md_ready = 1'b1; bus.md_result = 32'hCAFE_0007; bus.mw_writes = 1'b1;
    settle();
    chk("div7_steal_wb_en", {31'd0, bus.md_wb_en}, 32'd0);
    chk("div7_steal_hold", {31'd0, bus.hold_mw}, 32'd0);
    sb_q.push_back('{rd: 5'd7, data: 32'hCAFE_0007});
    tick();
    clear_inputs();
    bus.mw_writes = 1'b1;
    settle();
    chk("div7_pend_hold", {31'd0, bus.hold_mw}, 32'd1);
    chk("div7_pend_stall", {31'd0, bus.stall_fd}, 32'd1);
    chk("div7_pend_wb_en", {31'd0, bus.md_wb_en}, 32'd1);
    chk("div7_pend_busy", {31'd0, bus.md_busy}, 32'd1);
    tick();
    bus.mw_writes = 1'b0;
    settle();
    chk("div7_after", {29'd0, bus.hold_mw, bus.stall_fd, bus.md_wb_en}, 32'd0);

    // both decode bits set: mult wins
    issue(1'b1, 1'b1, 5'd9, "both");
    ready_free(32'h0000_0099, 5'd9, 32'h0000_0099, 1'b1, "both");

    // mul r0: never stalls, never writes
    set_fd(5'd0, 5'd0, 1'b1, 1'b1, 5'd0);
    issue(1'b1, 1'b0, 5'd0, "mul0");
    run_busy(4, 1'b0, "mul0");
    ready_free(32'h0000_0777, 5'd0, 32'd0, 1'b0, "mul0");
    clear_inputs();

    // ready on the last possible cycle is accepted
    issue(1'b0, 1'b1, 5'd11, "edge");
    run_busy(TO - 1, 1'b0, "edge");
    ready_free(32'h0BAD_F00D, 5'd11, 32'h0BAD_F00D, 1'b1, "edge");
    chk("edge_no_timeout", {31'd0, bus.md_timeout}, 32'd0);

    // div that never completes
    issue(1'b0, 1'b1, 5'd12, "tmo");
    run_busy(TO, 1'b0, "tmo");
    settle();
    chk("tmo_flag", {31'd0, bus.md_timeout}, 32'd1);
    chk("tmo_idle", {31'd0, bus.md_busy}, 32'd0);
    tick(); tick();
    settle();
    chk("tmo_sticky", {31'd0, bus.md_timeout}, 32'd1);
    issue(1'b1, 1'b0, 5'd13, "tmo_clr");
    chk("tmo_cleared", {31'd0, bus.md_timeout}, 32'd0);
    ready_free(32'h0000_0013, 5'd13, 32'h0000_0013, 1'b1, "tmo_clr");

`ifdef MD_EXCEPTION_EN
    set_fd(5'd30, 5'd0, 1'b0, 1'b0, 5'd0);
    issue(1'b0, 1'b1, 5'd3, "exc");
    run_busy(2, 1'b1, "exc");
    bus.md_exception = 1'b1;
    ready_free(32'h1111_2222, 5'd30, 32'd5, 1'b1, "exc");
    clear_inputs();
    issue(1'b1, 1'b0, 5'd0, "exc0");
    bus.md_exception = 1'b1;
    ready_free(32'h3333_4444, 5'd30, 32'd4, 1'b1, "exc0");
`else
    set_fd(5'd30, 5'd0, 1'b0, 1'b0, 5'd0);
    issue(1'b0, 1'b1, 5'd3, "exc");
    run_busy(2, 1'b0, "exc");
    bus.md_exception = 1'b1;
    ready_free(32'h1111_2222, 5'd3, 32'h1111_2222, 1'b1, "exc");
    clear_inputs();
`endif

    // asynchronous reset while a stolen-port write is pending
    issue(1'b1, 1'b0, 5'd5, "rst");
    run_busy(3, 1'b0, "rst");
    bus.md_ready = 1'b1; bus.md_result = 32'h5555_AAAA; bus.mw_writes = 1'b1;
    tick();
    clear_inputs();
    bus.dx_is_mult = 1'b1; bus.dx_rd = 5'd5;
    rst_n = 1'b0;
    settle();
    chk("rst_mid_outputs", {25'd0, bus.md_ctrl_mult, bus.md_ctrl_div, bus.stall_fd,
        bus.hold_mw, bus.md_wb_en, bus.md_busy, bus.md_timeout}, 32'd0);
    chk("rst_mid_wb", {bus.md_wb_data[26:0], bus.md_wb_rd}, 32'd0);
    tick();
    clear_inputs();
    rst_n = 1'b1;
    tick();
    settle();
    chk("rst_recover_idle", {31'd0, bus.md_busy}, 32'd0);
    issue(1'b1, 1'b0, 5'd21, "post_rst");
    ready_free(32'h0000_0021, 5'd21, 32'h0000_0021, 1'b1, "post_rst");

    tick(); tick();
    chk("sb_empty", sb_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
